dispense_ctrl: RTL

DISPENSE_CTRL -- requirements
Module: dispense_ctrl

---
 rtl/vend_pkg.sv | 37 +++
 rtl/dispense_ctrl_if.sv | 34 +++
 rtl/dispense_ctrl_ack_timer.sv | 37 +++
 rtl/dispense_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
//   state_e    : controller FSM states
//   PRICE_*    : default product prices (selection 01, 10, 11)
//   COIN_*     : coin denominations the hopper can eject
//   next_coin(): largest denomination not exceeding the remaining change
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_VEND,
    ST_CHANGE,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [4:0] PRICE_A_DEF = 5'd10;
  localparam logic [4:0] PRICE_B_DEF = 5'd15;
  localparam logic [4:0] PRICE_C_DEF = 5'd20;

  localparam int ACK_TIMEOUT_DEF = 200;

  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_1  = 5'd1;

  // Greedy choice: never returns more than change, so change - coin cannot underflow.
  function automatic logic [4:0] next_coin(input logic [4:0] change);
    logic [4:0] coin;
    if (change >= COIN_10)     coin = COIN_10;
    else if (change >= COIN_5) coin = COIN_5;
    else if (change != 5'd0)   coin = COIN_1;
    else                       coin = 5'd0;
    return coin;
  endfunction

endpackage

// File: rtl/dispense_ctrl_if.sv
// Bus between the dispense controller and its surroundings.
//   Inputs to the controller : cancel, amount_done, amount[4:0], product_sel[1:0],
//                              vend_ack, coin_ack
//   Outputs of the controller: vend_req, vend_sel[1:0], coin_req, coin_val[4:0],
//                              busy, txn_done, insufficient, fault
//   slave  : controller side
//   master : environment side (totalling stage, dispenser, hopper)
interface dispense_ctrl_if;
  logic       cancel;
  logic       amount_done;
  logic [4:0] amount;
  logic [1:0] product_sel;
  logic       vend_ack;
  logic       coin_ack;

  logic       vend_req;
  logic [1:0] vend_sel;
  logic       coin_req;
  logic [4:0] coin_val;
  logic       busy;
  logic       txn_done;
  logic       insufficient;
  logic       fault;

  modport slave (
    input  cancel, amount_done, amount, product_sel, vend_ack, coin_ack,
    output vend_req, vend_sel, coin_req, coin_val, busy, txn_done, insufficient, fault
  );

  modport master (
    output cancel, amount_done, amount, product_sel, vend_ack, coin_ack,
    input  vend_req, vend_sel, coin_req, coin_val, busy, txn_done, insufficient, fault
  );
endinterface

// File: rtl/dispense_ctrl_ack_timer.sv
// Clearable acknowledge-timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : return the count to zero (no request pending, or request acknowledged)
//   en_i       : a request is being held this cycle
//   timeout_o  : this is the LIMIT-th consecutive held cycle without acknowledge
module ack_timer #(
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q counts completed held cycles, so it reads LIMIT-1 during the LIMIT-th one.
  assign timeout_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/dispense_ctrl.sv
// Dispense controller: checks credit against the selected product's price,
// drives the dispenser, pays change coin by coin and guards both handshakes
// with a timeout that locks into FAULT until reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dispense_ctrl_if.slave (amount/selection in, vend and coin
//                handshakes, busy / txn_done / insufficient / fault status out)
module dispense_ctrl
  import vend_pkg::*;
#(
  parameter logic [4:0] PRICE_A     = PRICE_A_DEF,
  parameter logic [4:0] PRICE_B     = PRICE_B_DEF,
  parameter logic [4:0] PRICE_C     = PRICE_C_DEF,
  parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst_n,
  dispense_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [4:0] amount_q, amount_d;
  logic [1:0] sel_q, sel_d;
  logic [4:0] change_q, change_d;
  logic       gap_q, gap_d;       // forces one idle cycle after each coin ack

  logic [4:0] price;
  logic [4:0] coin;
  logic       timeout;

  logic       vend_req, coin_req, busy, txn_done, insufficient, fault;
  logic [1:0] vend_sel;
  logic [4:0] coin_val;

  always_comb begin
    unique case (sel_q)
      2'b01:   price = PRICE_A;
      2'b10:   price = PRICE_B;
      2'b11:   price = PRICE_C;
      default: price = 5'd0;
    endcase
  end

  assign coin = next_coin(change_q);

  ack_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!(vend_req || coin_req) || (vend_req && bus.vend_ack) || (coin_req && bus.coin_ack)),
    .en_i      (vend_req || coin_req),
    .timeout_o (timeout)
  );

  // State register plus the datapath registers that travel with it.
  // NOTE: the latched amount, selection and change are reset too, so nothing stale survives a reset taken mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      amount_q <= '0;
      sel_q    <= '0;
      change_q <= '0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      amount_q <= amount_d;
      sel_q    <= sel_d;
      change_q <= change_d;
      gap_q    <= gap_d;
    end
  end

  // Next-state and datapath-update logic.
  always_comb begin
    state_d  = state_q;
    amount_d = amount_q;
    sel_d    = sel_q;
    change_d = change_q;
    gap_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.amount_done) begin
          amount_d = bus.amount;
          sel_d    = bus.product_sel;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sel_q == 2'b00 || amount_q < price) begin
          change_d = amount_q;
          state_d  = ST_CHANGE;
        end else begin
          change_d = amount_q - price;
          state_d  = ST_VEND;
        end
      end
      ST_VEND: begin
        // Ack beats a same-cycle cancel: the product is already out.
        if (bus.vend_ack) begin
          state_d = ST_CHANGE;
        end else if (bus.cancel) begin
          change_d = amount_q;
          state_d  = ST_CHANGE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_CHANGE: begin
        if (change_q == 5'd0) begin
          state_d = ST_DONE;
        end else if (!gap_q) begin
          if (bus.coin_ack) begin
            change_d = change_q - coin;
            gap_d    = 1'b1;
          end else if (timeout) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state and latched data.
  always_comb begin
    vend_req     = 1'b0;
    vend_sel     = 2'b00;
    coin_req     = 1'b0;
    coin_val     = 5'd0;
    busy         = (state_q != ST_IDLE);
    txn_done     = 1'b0;
    insufficient = 1'b0;
    fault        = 1'b0;
    unique case (state_q)
      ST_CHECK:  insufficient = (sel_q != 2'b00) && (amount_q < price);
      ST_VEND: begin
        vend_req = 1'b1;
        vend_sel = sel_q;
      end
      ST_CHANGE: begin
        if (change_q != 5'd0 && !gap_q) begin
          coin_req = 1'b1;
          coin_val = coin;
        end
      end
      ST_DONE:   txn_done = 1'b1;
      ST_FAULT:  fault    = 1'b1;
      default:   ;
    endcase
  end

  assign bus.vend_req     = vend_req;
  assign bus.vend_sel     = vend_sel;
  assign bus.coin_req     = coin_req;
  assign bus.coin_val     = coin_val;
  assign bus.busy         = busy;
  assign bus.txn_done     = txn_done;
  assign bus.insufficient = insufficient;
  assign bus.fault        = fault;

endmodule
